// File: rtl/simd_regfile_lanes_if.sv
// Lane-packed bus between SIMD decode/ALU (master) and the register file (slave).
interface simd_regfile_lanes_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int ADDR_W = 4
);
  logic                     wr_en;
  logic [LANES-1:0]         wr_mask;
  logic [LANES*ADDR_W-1:0]  d_addr;
  logic [LANES*DATA_W-1:0]  wr_data;
  logic [LANES*ADDR_W-1:0]  s_addr;
  logic [LANES*ADDR_W-1:0]  t_addr;
  logic [LANES*DATA_W-1:0]  s_out;
  logic [LANES*DATA_W-1:0]  t_out;
  logic                     clr_req;
  logic                     busy;
  logic                     clr_done;

  modport master (
    output wr_en, wr_mask, d_addr, wr_data, s_addr, t_addr, clr_req,
    input  s_out, t_out, busy, clr_done
  );
  modport slave (
    input  wr_en, wr_mask, d_addr, wr_data, s_addr, t_addr, clr_req,
    output s_out, t_out, busy, clr_done
  );
endinterface

// File: rtl/simd_regfile_lanes.sv
// SIMD register file: per-lane S/T read and D write indices, reg 0 hardwired to zero,
// multi-cycle clear sequencer. Optional write-to-read forwarding under SIMD_RF_BYPASS_EN.

module simd_rf_rd_lane #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] view,
  input  logic [ADDR_W-1:0]            s_idx,
  input  logic [ADDR_W-1:0]            t_idx,
  output logic [DATA_W-1:0]            s_data,
  output logic [DATA_W-1:0]            t_data
);
  assign s_data = view[s_idx];
  assign t_data = view[t_idx];
endmodule

module simd_regfile_lanes #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  simd_regfile_lanes_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              cnt_q, cnt_d;
  logic                           clr_now;
  logic                           we;
  logic [DEPTH-1:1][DATA_W-1:0]   rf;
  logic [DEPTH-1:1]               wr_hit;
  logic [DEPTH-1:1][DATA_W-1:0]   wr_val;
  logic [DEPTH-1:0][DATA_W-1:0]   view;
  logic [LANES*DATA_W-1:0]        s_flat, t_flat;

  assign clr_now      = (state_q == CLEAR);
  assign we           = bus.wr_en && !clr_now;
  assign bus.busy     = clr_now;
  assign bus.clr_done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE behaves like IDLE for new requests; it only differs by the clr_done decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH-1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ascending lane scan: a later lane overwrites an earlier one on index collision
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int i = 0; i < LANES; i++) begin
      if (we && bus.wr_mask[i] && bus.d_addr[i*ADDR_W +: ADDR_W] != '0) begin
        wr_hit[bus.d_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[bus.d_addr[i*ADDR_W +: ADDR_W]] = bus.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf <= '0;
    end else begin
      for (int j = 1; j < DEPTH; j++) begin
        if (clr_now && cnt_q == ADDR_W'(j))
          rf[j] <= '0;
        else if (wr_hit[j])
          rf[j] <= wr_val[j];
      end
    end
  end

  always_comb begin
    view[0] = '0;
    for (int j = 1; j < DEPTH; j++) begin
`ifdef SIMD_RF_BYPASS_EN
      view[j] = wr_hit[j] ? wr_val[j] : rf[j];
`else
      view[j] = rf[j];
`endif
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_rf_rd_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
      .view   (view),
      .s_idx  (bus.s_addr[i*ADDR_W +: ADDR_W]),
      .t_idx  (bus.t_addr[i*ADDR_W +: ADDR_W]),
      .s_data (s_flat[i*DATA_W +: DATA_W]),
      .t_data (t_flat[i*DATA_W +: DATA_W])
    );
  end

  assign bus.s_out = s_flat;
  assign bus.t_out = t_flat;
endmodule

// File: tb/tb_simd_regfile_lanes.sv
// Bench for simd_regfile_lanes: directed table, random run against a reference model,
// and hand sequences for clear latency, reset mid-clear and forwarding.
module tb_simd_regfile_lanes;
  localparam int DATA_W = 32;
  localparam int LANES  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int W      = LANES*DATA_W;
  localparam int AW     = LANES*ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  simd_regfile_lanes_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus();
  simd_regfile_lanes #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] a_rep(input int v);
    logic [AW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ADDR_W +: ADDR_W] = ADDR_W'(v);
    return r;
  endfunction
  function automatic logic [AW-1:0] a_seq(input int start);
    logic [AW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ADDR_W +: ADDR_W] = ADDR_W'(start + i);
    return r;
  endfunction
  function automatic logic [W-1:0] d_rep(input logic [DATA_W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction
  function automatic logic [W-1:0] d_seq(input logic [DATA_W-1:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    return r;
  endfunction
  function automatic logic [W-1:0] set_lane(input logic [W-1:0] f, input int ln, input logic [DATA_W-1:0] v);
    logic [W-1:0] r;
    r = f;
    r[ln*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  task automatic drive(input logic we, input logic [LANES-1:0] m, input logic [AW-1:0] d,
                       input logic [W-1:0] dat, input logic [AW-1:0] s, input logic [AW-1:0] t,
                       input logic clr);
    bus.wr_en = we; bus.wr_mask = m; bus.d_addr = d; bus.wr_data = dat;
    bus.s_addr = s; bus.t_addr = t; bus.clr_req = clr;
  endtask
  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask
  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Reference model: array of registers plus "next index still to be cleared" (0 = no clear running)
  logic [DATA_W-1:0] m_rf [DEPTH] = '{default: '0};
  int                m_clr_next = 0;
  bit                m_done = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) m_rf[j] = '0;
      m_clr_next = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_clr_next != 0) begin
        m_rf[m_clr_next] = '0;
        if (m_clr_next == DEPTH-1) begin
          m_clr_next = 0;
          m_done = 1'b1;
        end else m_clr_next++;
      end else begin
        if (bus.wr_en)
          for (int i = 0; i < LANES; i++)
            if (bus.wr_mask[i] && bus.d_addr[i*ADDR_W +: ADDR_W] != 0)
              m_rf[bus.d_addr[i*ADDR_W +: ADDR_W]] = bus.wr_data[i*DATA_W +: DATA_W];
        if (bus.clr_req) m_clr_next = 1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] m_read(input int idx);
    logic [DATA_W-1:0] v;
    v = (idx == 0) ? '0 : m_rf[idx];
`ifdef SIMD_RF_BYPASS_EN
    if (m_clr_next == 0 && bus.wr_en && idx != 0)
      for (int i = 0; i < LANES; i++)
        if (bus.wr_mask[i] && int'(bus.d_addr[i*ADDR_W +: ADDR_W]) == idx)
          v = bus.wr_data[i*DATA_W +: DATA_W];
`endif
    return v;
  endfunction
  function automatic logic [W-1:0] m_flat(input logic [AW-1:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = m_read(int'(a[i*ADDR_W +: ADDR_W]));
    return r;
  endfunction

  typedef struct {
    logic             wr_en;
    logic [LANES-1:0] mask;
    logic [AW-1:0]    d_addr;
    logic [W-1:0]     wr_data;
    logic [AW-1:0]    s_addr;
    logic [AW-1:0]    t_addr;
    logic [W-1:0]     exp_s;
    logic [W-1:0]     exp_t;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int nb, pulses;
    bit fin, done_seen;
    logic [W-1:0] exp_fill;

    tbl[0] = '{1'b1, 8'hFF, a_rep(0), d_rep(32'hFFFF_FFFF), a_rep(0), a_seq(0), '0, '0};
    tbl[1] = '{1'b1, 8'hFF, a_seq(1), d_seq(32'hA0), a_seq(1), a_rep(0), d_seq(32'hA0), '0};
    tbl[2] = '{1'b1, 8'h24, a_rep(3),
               set_lane(set_lane(d_rep(32'h77), 2, 32'h22), 5, 32'h55),
               a_rep(3), a_seq(1), d_rep(32'h55), set_lane(d_seq(32'hA0), 2, 32'h55)};
    tbl[3] = '{1'b1, 8'h00, a_rep(5), d_rep(32'hFFFF_0000), a_rep(5), a_rep(3), d_rep(32'hA4), d_rep(32'h55)};
    tbl[4] = '{1'b0, 8'hFF, a_rep(6), d_rep(32'h1234_5678), a_rep(6), a_seq(8), d_rep(32'hA5),
               set_lane('0, 0, 32'hA7)};
    tbl[5] = '{1'b1, 8'hFF, a_rep(9), d_seq(32'h900), a_rep(9), a_rep(1), d_rep(32'h907), d_rep(32'hA0)};

    // Reset state
    idle();
    drive(1'b0, '0, '0, '0, a_seq(0), a_seq(8), 1'b0);
    @(negedge clk);
    chk("rst_s", bus.s_out, '0);
    chk("rst_t", bus.t_out, '0);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.clr_done), '0);
    next_cyc();
    reset = 1'b1;

    // Directed table: write cycle, then read cycle
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      drive(tbl[k].wr_en, tbl[k].mask, tbl[k].d_addr, tbl[k].wr_data, '0, '0, 1'b0);
      next_cyc();
      drive(1'b0, '0, '0, '0, tbl[k].s_addr, tbl[k].t_addr, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_s", k), bus.s_out, tbl[k].exp_s);
      chk($sformatf("tbl%0d_t", k), bus.t_out, tbl[k].exp_t);
    end

    // Random traffic against the model
    next_cyc();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 9) < 7), LANES'($urandom), AW'({$urandom, $urandom}),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            AW'($urandom), AW'($urandom), ($urandom_range(0, 29) == 0));
      @(negedge clk);
      chk("rnd_s", bus.s_out, m_flat(bus.s_addr));
      chk("rnd_t", bus.t_out, m_flat(bus.t_addr));
      chk("rnd_busy", W'(bus.busy), W'(m_clr_next != 0));
      chk("rnd_done", W'(bus.clr_done), W'(m_done));
      next_cyc();
    end
    idle();
    repeat (20) next_cyc();

    // Clear latency, busy write drop, final zeroing
    drive(1'b1, 8'hFF, a_seq(1), d_seq(32'h100), '0, '0, 1'b0);
    next_cyc();
    drive(1'b1, 8'hFF, a_seq(8), d_seq(32'h200), '0, '0, 1'b0);
    next_cyc();
    drive(1'b0, '0, '0, '0, a_seq(1), a_seq(8), 1'b0);
    @(negedge clk);
    exp_fill = set_lane(d_seq(32'h100), 7, 32'h200);
    chk("fill_s", bus.s_out, exp_fill);
    chk("fill_t", bus.t_out, d_seq(32'h200));
    next_cyc();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b1);
    next_cyc();
    idle();
    nb = 0; fin = 0; done_seen = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        nb++;
        drive(1'b1, 8'hFF, a_seq(1), d_rep(32'hDEAD), '0, '0, 1'b0);
      end else begin
        fin = 1;
        done_seen = bus.clr_done;
        idle();
      end
    end
    if (!fin) chk("clr_timeout", W'(fin), W'(1));
    chk("clr_busy_cycles", W'(nb), W'(DEPTH-1));
    chk("clr_done_pulse", W'(done_seen), W'(1));
    @(negedge clk);
    chk("clr_done_drop", W'(bus.clr_done), '0);
    drive(1'b0, '0, '0, '0, a_seq(0), a_seq(8), 1'b0);
    #1;
    chk("clr_zero_s", bus.s_out, '0);
    chk("clr_zero_t", bus.t_out, '0);

    // Reset asserted in clear cycle 5
    next_cyc();
    drive(1'b1, 8'hFF, a_seq(1), d_seq(32'h300), '0, '0, 1'b0);
    next_cyc();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b1);
    next_cyc();
    idle();
    nb = 0;
    for (int c = 0; c < 40 && nb < 5; c++) begin
      @(negedge clk);
      if (bus.busy) nb++;
    end
    chk("rstmid_reach5", W'(nb), W'(5));
    #2 reset = 1'b0;
    drive(1'b0, '0, '0, '0, a_seq(0), a_seq(8), 1'b0);
    #1;
    chk("rstmid_busy", W'(bus.busy), '0);
    chk("rstmid_done", W'(bus.clr_done), '0);
    chk("rstmid_s", bus.s_out, '0);
    chk("rstmid_t", bus.t_out, '0);
    next_cyc();
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.clr_done) pulses++;
    end
    chk("rstmid_no_done", W'(pulses), '0);
    next_cyc();
    drive(1'b1, 8'h01, a_rep(7), d_rep(32'h1234), '0, '0, 1'b0);
    next_cyc();
    drive(1'b0, '0, '0, '0, a_rep(7), '0, 1'b0);
    @(negedge clk);
    chk("post_rst_wr", W'(bus.s_out[DATA_W-1:0]), W'(32'h1234));

    // Forwarding behaviour on the same-cycle read
    next_cyc();
    drive(1'b1, 8'h01, a_rep(4), d_rep(32'h4444), '0, '0, 1'b0);
    next_cyc();
    drive(1'b1, 8'h01, a_rep(4), d_rep(32'hBEEF), a_rep(4), '0, 1'b0);
    @(negedge clk);
`ifdef SIMD_RF_BYPASS_EN
    chk("byp_same", W'(bus.s_out[DATA_W-1:0]), W'(32'hBEEF));
`else
    chk("byp_same", W'(bus.s_out[DATA_W-1:0]), W'(32'h4444));
`endif
    next_cyc();
    drive(1'b0, '0, '0, '0, a_rep(4), '0, 1'b0);
    @(negedge clk);
    chk("byp_next", W'(bus.s_out[DATA_W-1:0]), W'(32'hBEEF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/simd_regfile_lanes.md
Name: simd_regfile_lanes

Overview:
- Parametrised SIMD register file: DEPTH registers of DATA_W bits, accessed as LANES lanes per port.
- Each lane has its own register index on S, T and D ports. Per-lane write mask.
- Register 0 is hardwired to zero.
- A multi-cycle clear sequencer zeroes the whole file on request.
- Sits between SIMD decode (addresses) and SIMD ALU (S/T operands, D writeback) in the vector datapath.

Parameters:
- DATA_W, 32, bits per lane/register.
- LANES, 8, lanes per access.
- DEPTH, 16, number of registers; power of two, at least 2.
- ADDR_W, 4, bits per lane index; must equal log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  writeback strobe.
- wr_mask  in  LANES  per-lane write enable; bit i gates lane i.
- d_addr  in  LANES*ADDR_W  destination index; lane i at [i*ADDR_W +: ADDR_W].
- wr_data  in  LANES*DATA_W  writeback data; lane i at [i*DATA_W +: DATA_W].
- s_addr  in  LANES*ADDR_W  S operand indices, same packing as d_addr.
- t_addr  in  LANES*ADDR_W  T operand indices, same packing as d_addr.
- s_out  out  LANES*DATA_W  S operand data, lane i at [i*DATA_W +: DATA_W].
- t_out  out  LANES*DATA_W  T operand data, same packing as s_out.
- clr_req  in  1  start a full clear.
- busy  out  1  clear in progress; writes are ignored.
- clr_done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0; FSM = IDLE; clear counter = 0.
  - busy=0, clr_done=0; s_out/t_out read all zeros.
  - Release is synchronous to the clk rise.
- Reads:
  - Combinational: lane i of s_out = REG[s_addr lane i]; same for t_out.
  - Index 0 always reads 0.
  - Reads are valid in every state, including CLEAR, where they return partially cleared contents.
- Writes (rising edge, only when wr_en=1 and busy=0):
  - For each lane i with wr_mask[i]=1: REG[d_addr lane i] <= wr_data lane i.
  - Writes to index 0 are discarded.
  - wr_mask=0 or wr_en=0: no state change.
  - Collision (two enabled lanes with the same index): the highest-numbered lane wins.
  - Writes while busy=1 are dropped silently; the producer must hold off using busy.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 at an edge -> CLEAR, counter <= 1. A write in the same edge still commits.
  - CLEAR: busy=1. Each edge, REG[counter] <= 0 and counter++. When counter = DEPTH-1 is cleared -> DONE.
  - DONE: busy=0, clr_done=1 for exactly one cycle -> IDLE. A write or clr_req in DONE is accepted as in IDLE.
  - clr_req while in CLEAR: ignored, no queueing.
  - Latency: clr_req sampled at edge N -> busy high for cycles N+1..N+DEPTH-1 (DEPTH-1 cycles) -> clr_done high in cycle N+DEPTH.
  - Counter is ADDR_W bits; it never wraps because the exit happens at DEPTH-1.
- Reset asserted mid-clear: immediate return to IDLE with all registers zero. No clr_done pulse.
- busy and clr_done are registered outputs, decoded from FSM state flops.

Optional Feature:
- Macro SIMD_RF_BYPASS_EN.
- Defined: write-to-read forwarding. If a lane's s/t index equals an index being written this cycle (wr_en=1, busy=0, mask set, index≠0), that read lane returns the incoming wr_data, using the same highest-lane-wins priority.
- Undefined: reads return stored contents only; new data is visible the cycle after the edge.

Test Plan:
- Reset, then read all indices -> s_out = t_out = 0. Write index 0 with 32'hFFFFFFFF, all lanes -> still reads 0.
- wr_en=1, wr_mask=8'hFF, d_addr lanes = 1..8, wr_data lane i = 32'hA0+i -> next cycle s_addr lane i = i+1 reads 32'hA0+i.
- Collision: lanes 2 and 5 both target index 3 with data 32'h22 / 32'h55, mask=8'h24 -> REG[3]=32'h55. wr_mask=8'h00 -> no register changes.
- Fill regs 1..15 nonzero, pulse clr_req -> busy high for exactly 15 cycles, clr_done one cycle after, all regs 0. Writes issued during busy -> dropped.
- Assert reset at clear cycle 5 -> busy=0 immediately, no clr_done, all regs 0. A subsequent write of 32'h1234 to index 7 succeeds.
- Bypass: with SIMD_RF_BYPASS_EN, write 32'hBEEF to index 4 while s_addr lane 0 = 4 -> s_out lane 0 = 32'hBEEF the same cycle. Without the macro -> old value that cycle, 32'hBEEF the next.
